// File: rtl/frame_feeder_if.sv
// Pixel stream handshake between the camera/host side (master) and the frame feeder (slave).
interface frame_feeder_if #(
  parameter int PIX_W = 8
);
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             pix_last;
  logic             pix_ready;

  modport master (output pix_valid, pix_data, pix_last, input pix_ready);
  modport slave  (input pix_valid, pix_data, pix_last, output pix_ready);
endinterface

// File: rtl/frame_feeder.sv
// frame_feeder: loads one picture_size x picture_size frame into the picture database,
// pulses GO, waits for STOP and reports RESULT. Define FEEDER_TIMEOUT_EN to add a watchdog.
module frame_feeder #(
  parameter int SIZE_1         = 11,
  parameter int picture_size   = 28,
  parameter int PIX_W          = 8,
  parameter int PIX_SHIFT      = 1,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  frame_feeder_if.slave            pix,
  output logic                     we_database,
  output logic signed [SIZE_1-1:0] dp_database,
  output logic [12:0]              address_p_database,
  output logic                     GO,
  input  logic                     STOP,
  input  logic [3:0]               RESULT,
  output logic [3:0]               digit,
  output logic                     digit_valid,
  output logic                     busy,
  output logic                     err_frame
);

  localparam int FRAME_LEN = picture_size * picture_size;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_RUN,
    WAIT_DONE,
    REPORT
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              take;
  logic [SIZE_1-1:0] pix_word;

`ifdef FEEDER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd;
`endif

  assign take     = pix.pix_valid & pix.pix_ready;
  assign pix_word = SIZE_1'(pix.pix_data) >> PIX_SHIFT;

  // STOP is only trusted after GO: it is never looked at in IDLE, LOAD or START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      pix.pix_ready      <= 1'b0;
      we_database        <= 1'b0;
      dp_database        <= '0;
      address_p_database <= '0;
      GO                 <= 1'b0;
      digit              <= 4'hF;
      digit_valid        <= 1'b0;
      busy               <= 1'b0;
      err_frame          <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
      wd                 <= '0;
`endif
    end else begin
      we_database <= 1'b0;
      GO          <= 1'b0;
      digit_valid <= 1'b0;
      case (state)
        IDLE: begin
          pix.pix_ready <= 1'b1;
          if (take) begin
            we_database        <= 1'b1;
            address_p_database <= '0;
            dp_database        <= pix_word;
            err_frame          <= pix.pix_last;
            if (!pix.pix_last) begin
              state <= LOAD;
              cnt   <= CNT_W'(1);
              busy  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (take) begin
            we_database        <= 1'b1;
            address_p_database <= 13'(cnt);
            dp_database        <= pix_word;
            if (cnt == LAST_IDX) begin
              // A missing pix_last on the final pixel is flagged but the frame still runs.
              state         <= START;
              cnt           <= '0;
              pix.pix_ready <= 1'b0;
              if (!pix.pix_last) err_frame <= 1'b1;
            end else if (pix.pix_last) begin
              state     <= IDLE;
              cnt       <= '0;
              busy      <= 1'b0;
              err_frame <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        START: begin
          GO    <= 1'b1;
          state <= WAIT_RUN;
`ifdef FEEDER_TIMEOUT_EN
          wd    <= '0;
`endif
        end
        WAIT_RUN: begin
`ifdef FEEDER_TIMEOUT_EN
          wd <= wd + WD_W'(1);
          if (!STOP) begin
            state <= WAIT_DONE;
          end else if (wd == WD_LAST) begin
            state       <= REPORT;
            digit       <= 4'hF;
            digit_valid <= 1'b1;
            err_frame   <= 1'b1;
          end
`else
          if (!STOP) state <= WAIT_DONE;
`endif
        end
        WAIT_DONE: begin
`ifdef FEEDER_TIMEOUT_EN
          wd <= wd + WD_W'(1);
          if (STOP) begin
            state       <= REPORT;
            digit       <= RESULT;
            digit_valid <= 1'b1;
          end else if (wd == WD_LAST) begin
            state       <= REPORT;
            digit       <= 4'hF;
            digit_valid <= 1'b1;
            err_frame   <= 1'b1;
          end
`else
          if (STOP) begin
            state       <= REPORT;
            digit       <= RESULT;
            digit_valid <= 1'b1;
          end
`endif
        end
        REPORT: begin
          state         <= IDLE;
          busy          <= 1'b0;
          pix.pix_ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_feeder.sv
// Self-checking bench for frame_feeder: database writes are scoreboarded, the network is modelled.
module tb_frame_feeder;

  localparam int SIZE_1    = 11;
  localparam int PIX_W     = 8;
  localparam int PIX_SHIFT = 1;
  localparam int FRAME     = 784;
  localparam int TO_CYC    = 1000;

  typedef struct {
    logic [12:0]       addr;
    logic [SIZE_1-1:0] data;
  } wr_t;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     STOP = 1'b1;
  logic [3:0]               RESULT = 4'h0;
  logic                     we_database;
  logic signed [SIZE_1-1:0] dp_database;
  logic [12:0]              address_p_database;
  logic                     GO;
  logic [3:0]               digit;
  logic                     digit_valid;
  logic                     busy;
  logic                     err_frame;

  int  checks = 0;
  int  fails = 0;
  int  cyc = 0;
  int  go_count = 0;
  int  go_cyc = -1;
  int  last_wr_cyc = -1;
  wr_t exp_q[$];
  wr_t mon_e;

  frame_feeder_if #(.PIX_W(PIX_W)) pix ();

  frame_feeder #(
    .SIZE_1(SIZE_1),
    .picture_size(28),
    .PIX_W(PIX_W),
    .PIX_SHIFT(PIX_SHIFT),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pix(pix),
    .we_database(we_database),
    .dp_database(dp_database),
    .address_p_database(address_p_database),
    .GO(GO),
    .STOP(STOP),
    .RESULT(RESULT),
    .digit(digit),
    .digit_valid(digit_valid),
    .busy(busy),
    .err_frame(err_frame)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Every database write must match the oldest pixel handshake still outstanding.
  always @(negedge clk) begin
    if (we_database === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_write: addr=%0d data=0x%0h, required no write",
                 address_p_database, dp_database);
      end else begin
        mon_e = exp_q.pop_front();
        if (address_p_database !== mon_e.addr || dp_database !== mon_e.data) begin
          fails++;
          $display("[TB] FAIL db_write: addr=%0d data=0x%0h, required addr=%0d data=0x%0h",
                   address_p_database, dp_database, mon_e.addr, mon_e.data);
        end
      end
      if (address_p_database == 13'd783) last_wr_cyc = cyc;
    end
    if (GO === 1'b1) begin
      go_count++;
      go_cyc = cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_frame(input int n, input int last_idx, input bit throttle,
                             input bit all_ff, input string tag);
    int k = 0;
    int c = 0;
    logic [7:0] d;
    wr_t e;
    while (k < n && c < 4 * n + 20) begin
      tick();
      if (throttle && (c % 2 == 1)) begin
        pix.pix_valid = 1'b0;
        pix.pix_last  = 1'b0;
      end else begin
        d = all_ff ? 8'hFF : 8'(k);
        pix.pix_valid = 1'b1;
        pix.pix_data  = d;
        pix.pix_last  = (k == last_idx);
      end
      if (pix.pix_valid === 1'b1 && pix.pix_ready === 1'b1) begin
        e.addr = 13'(k);
        e.data = SIZE_1'(d) >> PIX_SHIFT;
        exp_q.push_back(e);
        k++;
      end
      c++;
    end
    tick();
    pix.pix_valid = 1'b0;
    pix.pix_last  = 1'b0;
    checks++;
    if (k != n) begin
      fails++;
      $display("[TB] FAIL %s_accepted: %0d pixels accepted, required %0d", tag, k, n);
    end
  endtask

  task automatic wait_go(input int go_before, input string tag);
    int w = 0;
    while (go_count == go_before && w < 100) begin
      tick();
      w++;
    end
    checks++;
    if (go_count != go_before + 1) begin
      fails++;
      $display("[TB] FAIL %s_go_seen: %0d GO pulses, required %0d", tag, go_count - go_before, 1);
    end
  endtask

  task automatic run_network(input int go_before, input logic [3:0] res, input bit exp_err,
                             input string tag);
    wait_go(go_before, tag);
    checks++;
    if (go_cyc != last_wr_cyc + 1) begin
      fails++;
      $display("[TB] FAIL %s_go_timing: GO at cycle %0d, required %0d", tag, go_cyc, last_wr_cyc + 1);
    end
    repeat (2) tick();
    STOP = 1'b0;
    RESULT = 4'h0;
    repeat (250) tick();
    checks++;
    if (pix.pix_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s_wait_done: pix_ready=%b busy=%b, required pix_ready=0 busy=1",
               tag, pix.pix_ready, busy);
    end
    repeat (250) tick();
    STOP = 1'b1;
    RESULT = res;
    tick();
    checks++;
    if (digit_valid !== 1'b1 || digit !== res) begin
      fails++;
      $display("[TB] FAIL %s_report: digit_valid=%b digit=%h, required 1 and %h",
               tag, digit_valid, digit, res);
    end
    tick();
    checks++;
    if (digit_valid !== 1'b0 || busy !== 1'b0 || pix.pix_ready !== 1'b1 ||
        err_frame !== exp_err || go_count != go_before + 1 || exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL %s_after_report: dv=%b busy=%b ready=%b err=%b gos=%0d pend=%0d, required dv=0 busy=0 ready=1 err=%b gos=1 pend=0",
               tag, digit_valid, busy, pix.pix_ready, err_frame, go_count - go_before,
               exp_q.size(), exp_err);
    end
  endtask

  task automatic test_reset();
    pix.pix_valid = 1'b0;
    pix.pix_data  = '0;
    pix.pix_last  = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (pix.pix_ready !== 1'b0 || we_database !== 1'b0 || dp_database !== '0 ||
        address_p_database !== '0 || GO !== 1'b0 || digit !== 4'hF || digit_valid !== 1'b0 ||
        busy !== 1'b0 || err_frame !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_values: ready=%b we=%b dp=%h addr=%h go=%b digit=%h dv=%b busy=%b err=%b, required all 0 except digit=f",
               pix.pix_ready, we_database, dp_database, address_p_database, GO, digit,
               digit_valid, busy, err_frame);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (pix.pix_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_idle: ready=%b busy=%b, required ready=1 busy=0", pix.pix_ready, busy);
    end
  endtask

  task automatic test_full_frame();
    int g = go_count;
    drive_frame(FRAME, FRAME - 1, 1'b0, 1'b0, "full");
    run_network(g, 4'd7, 1'b0, "full");
  endtask

  task automatic test_short_frame();
    int g = go_count;
    drive_frame(100, 99, 1'b0, 1'b0, "short");
    repeat (3) tick();
    checks++;
    if (err_frame !== 1'b1 || busy !== 1'b0 || pix.pix_ready !== 1'b1 ||
        go_count != g || exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL short_frame: err=%b busy=%b ready=%b gos=%0d pend=%0d, required err=1 busy=0 ready=1 gos=0 pend=0",
               err_frame, busy, pix.pix_ready, go_count - g, exp_q.size());
    end
    g = go_count;
    drive_frame(FRAME, FRAME - 1, 1'b0, 1'b0, "recover");
    run_network(g, 4'd2, 1'b0, "recover");
  endtask

  task automatic test_no_last();
    int g = go_count;
    drive_frame(FRAME, -1, 1'b0, 1'b0, "nolast");
    run_network(g, 4'd5, 1'b1, "nolast");
  endtask

  task automatic test_back_to_back();
    int g = go_count;
    drive_frame(FRAME, FRAME - 1, 1'b1, 1'b1, "throttle");
    run_network(g, 4'd3, 1'b0, "throttle");
  endtask

  task automatic test_reset_mid();
    int g = go_count;
    drive_frame(FRAME, FRAME - 1, 1'b0, 1'b0, "midrst");
    wait_go(g, "midrst");
    repeat (2) tick();
    STOP = 1'b0;
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || GO !== 1'b0 || digit !== 4'hF || digit_valid !== 1'b0 ||
        pix.pix_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midrst_values: busy=%b go=%b digit=%h dv=%b ready=%b, required 0 0 f 0 0",
               busy, GO, digit, digit_valid, pix.pix_ready);
    end
    tick();
    rst_n = 1'b1;
    STOP = 1'b1;
    tick();
    g = go_count;
    drive_frame(FRAME, FRAME - 1, 1'b0, 1'b0, "postrst");
    run_network(g, 4'd9, 1'b0, "postrst");
  endtask

`ifdef FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    int g = go_count;
    int w = 0;
    drive_frame(FRAME, FRAME - 1, 1'b0, 1'b0, "timeout");
    wait_go(g, "timeout");
    repeat (2) tick();
    STOP = 1'b0;
    while (digit_valid !== 1'b1 && w < TO_CYC + 100) begin
      tick();
      w++;
    end
    checks++;
    if (digit_valid !== 1'b1 || cyc != go_cyc + TO_CYC || digit !== 4'hF || err_frame !== 1'b1) begin
      fails++;
      $display("[TB] FAIL timeout_report: dv=%b at cycle %0d digit=%h err=%b, required dv=1 at cycle %0d digit=f err=1",
               digit_valid, cyc, digit, err_frame, go_cyc + TO_CYC);
    end
    STOP = 1'b1;
    repeat (2) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_no_last();
    test_back_to_back();
    test_reset_mid();
`ifdef FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "[TB] global timeout");
  end

endmodule
